// File: rtl/jk_excitation_driver_if.sv
// Bus between the JK excitation driver, its controller and the external JK bank.
// Covers the target handshake, bank feedback/drive and status; clk/rst stay plain ports.
interface jk_excitation_driver_if #(
    parameter int WIDTH = 8
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       retry_cnt;

    // Controller and bank side: offers targets and reports bank Q.
    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, j_out, k_out, busy, done, err, retry_cnt
    );

    // Driver side.
    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, j_out, k_out, busy, done, err, retry_cnt
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external JK bank so that it reaches a requested target, verifying and retrying.
// Optional macro JK_DRIVER_ERR_CNT_EN adds a saturating err_cnt[7:0] output.
module jk_excitation_driver #(
    parameter int WIDTH     = 8,
    parameter int DC_MODE   = 0,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    jk_excitation_driver_if.slave bus
`ifdef JK_DRIVER_ERR_CNT_EN
    ,
    output logic [7:0]           err_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [2:0]       retry_q, retry_d;

    logic [WIDTH-1:0] drive_tgt;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;

    // The first drive uses the word being accepted; retries reuse the latched target.
    assign drive_tgt = (state_q == IDLE) ? bus.tgt_data : tgt_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
        if (DC_MODE == 1) begin : g_setreset
            assign exc_j[gi] = drive_tgt[gi];
            assign exc_k[gi] = ~drive_tgt[gi];
        end else begin : g_minimal
            assign exc_j[gi] = ~bus.q_fb[gi] & drive_tgt[gi];
            assign exc_k[gi] = bus.q_fb[gi] & ~drive_tgt[gi];
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        retry_d = retry_q;
        unique case (state_q)
            IDLE: begin
                if (bus.tgt_valid) begin
                    tgt_d   = bus.tgt_data;
                    retry_d = 3'd0;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (bus.q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < MAX_RETRY_C) begin
                    retry_d = retry_q + 3'd1;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            retry_q <= 3'd0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
            retry_q <= retry_d;
        end
    end

    assign bus.tgt_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.j_out     = j_q;
    assign bus.k_out     = k_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.retry_cnt = retry_q;

`ifdef JK_DRIVER_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver: two instances (DC_MODE 0 and 1) each driving a behavioural JK bank.
// Bit-0 stuck-at-0 fault injection on bank 0 feedback exercises retry and error paths.
module tb_jk_excitation_driver;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jk_excitation_driver_if #(.WIDTH(W)) if0 ();
    jk_excitation_driver_if #(.WIDTH(W)) if1 ();

    logic [W-1:0] bank0, bank1, stuck0, load_val0, load_val1;
    logic         load_en;
    int           total = 0;
    int           bad   = 0;

`ifdef JK_DRIVER_ERR_CNT_EN
    logic [7:0] err_cnt0, err_cnt1;
`endif

    assign if0.q_fb = bank0 & ~stuck0;
    assign if1.q_fb = bank1;

    // Behavioural JK bank: Q+ = J & ~Q | ~K & Q, with a preload path for the bench.
    always @(posedge clk) begin
        if (load_en) begin
            bank0 <= load_val0;
            bank1 <= load_val1;
        end else begin
            bank0 <= (if0.j_out & ~bank0) | (~if0.k_out & bank0);
            bank1 <= (if1.j_out & ~bank1) | (~if1.k_out & bank1);
        end
    end

    jk_excitation_driver #(.WIDTH(W), .DC_MODE(0), .MAX_RETRY(3)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0)
`ifdef JK_DRIVER_ERR_CNT_EN
        , .err_cnt(err_cnt0)
`endif
    );

    jk_excitation_driver #(.WIDTH(W), .DC_MODE(1), .MAX_RETRY(3)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1)
`ifdef JK_DRIVER_ERR_CNT_EN
        , .err_cnt(err_cnt1)
`endif
    );

    task automatic load_banks(input logic [W-1:0] v0, input logic [W-1:0] v1);
        load_en   = 1'b1;
        load_val0 = v0;
        load_val1 = v1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Offers a target for one cycle; returns at the negedge of the first DRIVE cycle.
    task automatic start0(input logic [W-1:0] t);
        $display("txn dut0 target=%h q_fb=%h", t, if0.q_fb);
        if0.tgt_valid = 1'b1;
        if0.tgt_data  = t;
        @(negedge clk);
        if0.tgt_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if0.tgt_valid = 1'b0; if0.tgt_data = '0;
        if1.tgt_valid = 1'b0; if1.tgt_data = '0;
        stuck0 = '0;
        load_en = 1'b1; load_val0 = '0; load_val1 = '0;
        @(negedge clk);
        @(negedge clk);
        load_en = 1'b0;
        total++; if ({if0.j_out, if0.k_out} !== 16'h0000) begin bad++; $display("FAIL reset_jk: got %h expected 0000", {if0.j_out, if0.k_out}); end
        total++; if ({if0.done, if0.err, if0.busy} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", {if0.done, if0.err, if0.busy}); end
        total++; if (if0.retry_cnt !== 3'd0) begin bad++; $display("FAIL reset_retry: got %0d expected 0", if0.retry_cnt); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (if0.tgt_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", if0.tgt_ready); end
        $display("txn reset released");
    endtask

    task automatic test_basic;
        load_banks(8'h00, 8'h00);
        start0(8'hA5);
        total++; if (if0.j_out !== 8'hA5 || if0.k_out !== 8'h00) begin bad++; $display("FAIL basic_jk: got j=%h k=%h expected j=a5 k=00", if0.j_out, if0.k_out); end
        total++; if (if0.busy !== 1'b1 || if0.tgt_ready !== 1'b0) begin bad++; $display("FAIL basic_busy: got busy=%b ready=%b expected 1 0", if0.busy, if0.tgt_ready); end
        @(negedge clk);
        total++; if (if0.done !== 1'b0 || if0.j_out !== 8'h00) begin bad++; $display("FAIL basic_check: got done=%b j=%h expected 0 00", if0.done, if0.j_out); end
        @(negedge clk);
        total++; if (if0.done !== 1'b1 || if0.err !== 1'b0) begin bad++; $display("FAIL basic_done: got done=%b err=%b expected 1 0", if0.done, if0.err); end
        total++; if (if0.q_fb !== 8'hA5 || if0.retry_cnt !== 3'd0) begin bad++; $display("FAIL basic_final: got q=%h retry=%0d expected a5 0", if0.q_fb, if0.retry_cnt); end
        total++; if (if0.tgt_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b expected 1", if0.tgt_ready); end
    endtask

    task automatic test_dc_modes;
        logic [W-1:0] tgts [2];
        logic [W-1:0] ej0 [2];
        logic [W-1:0] ek0 [2];
        tgts[0] = 8'h3C; ej0[0] = 8'h0C; ek0[0] = 8'hC0;
        tgts[1] = 8'h3C; ej0[1] = 8'h00; ek0[1] = 8'h00;
        load_banks(8'hF0, 8'hF0);
        for (int i = 0; i < 2; i++) begin
            $display("txn both target=%h q0=%h q1=%h", tgts[i], if0.q_fb, if1.q_fb);
            if0.tgt_valid = 1'b1; if0.tgt_data = tgts[i];
            if1.tgt_valid = 1'b1; if1.tgt_data = tgts[i];
            @(negedge clk);
            if0.tgt_valid = 1'b0; if1.tgt_valid = 1'b0;
            total++; if (if0.j_out !== ej0[i] || if0.k_out !== ek0[i]) begin bad++; $display("FAIL dc0_jk[%0d]: got j=%h k=%h expected j=%h k=%h", i, if0.j_out, if0.k_out, ej0[i], ek0[i]); end
            total++; if (if1.j_out !== 8'h3C || if1.k_out !== 8'hC3) begin bad++; $display("FAIL dc1_jk[%0d]: got j=%h k=%h expected j=3c k=c3", i, if1.j_out, if1.k_out); end
            @(negedge clk);
            @(negedge clk);
            total++; if (if0.done !== 1'b1 || if1.done !== 1'b1) begin bad++; $display("FAIL dc_done[%0d]: got %b%b expected 11", i, if0.done, if1.done); end
            total++; if (if0.q_fb !== 8'h3C || if1.q_fb !== 8'h3C) begin bad++; $display("FAIL dc_final[%0d]: got %h %h expected 3c 3c", i, if0.q_fb, if1.q_fb); end
        end
    endtask

    task automatic test_retry_err;
        logic [W-1:0] ej;
        load_banks(8'h00, 8'h3C);
        stuck0 = 8'h01;
        start0(8'h01);
        for (int c = 1; c <= 9; c++) begin
            ej = ((c % 2 == 1) && (c <= 7)) ? 8'h01 : 8'h00;
            total++; if (if0.j_out !== ej || if0.done !== 1'b0) begin bad++; $display("FAIL retry_cyc%0d: got j=%h done=%b expected j=%h done=0", c, if0.j_out, if0.done, ej); end
            total++; if (if0.err !== (c == 9)) begin bad++; $display("FAIL retry_err_cyc%0d: got %b expected %b", c, if0.err, (c == 9)); end
            if (c < 9) @(negedge clk);
        end
        total++; if (if0.retry_cnt !== 3'd3 || if0.tgt_ready !== 1'b1) begin bad++; $display("FAIL retry_final: got retry=%0d ready=%b expected 3 1", if0.retry_cnt, if0.tgt_ready); end
`ifdef JK_DRIVER_ERR_CNT_EN
        total++; if (err_cnt0 !== 8'd1 || err_cnt1 !== 8'd0) begin bad++; $display("FAIL err_cnt: got %0d %0d expected 1 0", err_cnt0, err_cnt1); end
`endif
        @(negedge clk);
        total++; if (if0.retry_cnt !== 3'd3 || if0.err !== 1'b0) begin bad++; $display("FAIL retry_hold: got retry=%0d err=%b expected 3 0", if0.retry_cnt, if0.err); end
        stuck0 = 8'h00;
    endtask

    task automatic test_back_to_back;
        load_banks(8'h00, 8'h3C);
        $display("txn dut0 target=11 then 22 back-to-back");
        if0.tgt_valid = 1'b1; if0.tgt_data = 8'h11;
        @(negedge clk);
        if0.tgt_data = 8'h22;
        total++; if (if0.tgt_ready !== 1'b0 || if0.j_out !== 8'h11) begin bad++; $display("FAIL b2b_first: got ready=%b j=%h expected 0 11", if0.tgt_ready, if0.j_out); end
        @(negedge clk);
        total++; if (if0.tgt_ready !== 1'b0 || if0.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got ready=%b busy=%b expected 0 1", if0.tgt_ready, if0.busy); end
        @(negedge clk);
        total++; if (if0.done !== 1'b1 || if0.tgt_ready !== 1'b1 || if0.q_fb !== 8'h11) begin bad++; $display("FAIL b2b_done1: got done=%b ready=%b q=%h expected 1 1 11", if0.done, if0.tgt_ready, if0.q_fb); end
        @(negedge clk);
        if0.tgt_valid = 1'b0;
        total++; if (if0.j_out !== 8'h22 || if0.k_out !== 8'h11 || if0.done !== 1'b0) begin bad++; $display("FAIL b2b_second: got j=%h k=%h done=%b expected 22 11 0", if0.j_out, if0.k_out, if0.done); end
        @(negedge clk);
        @(negedge clk);
        total++; if (if0.done !== 1'b1 || if0.q_fb !== 8'h22) begin bad++; $display("FAIL b2b_done2: got done=%b q=%h expected 1 22", if0.done, if0.q_fb); end
    endtask

    task automatic test_reset_mid;
        load_banks(8'h00, 8'h3C);
        stuck0 = 8'h01;
        start0(8'h01);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total++; if (if0.busy !== 1'b1 || if0.retry_cnt !== 3'd1) begin bad++; $display("FAIL mid_pre: got busy=%b retry=%0d expected 1 1", if0.busy, if0.retry_cnt); end
        #2 rst = 1'b1;
        #1;
        total++; if ({if0.j_out, if0.k_out} !== 16'h0000 || if0.busy !== 1'b0 || if0.retry_cnt !== 3'd0) begin bad++; $display("FAIL mid_abort: got jk=%h busy=%b retry=%0d expected 0000 0 0", {if0.j_out, if0.k_out}, if0.busy, if0.retry_cnt); end
        total++; if (if0.done !== 1'b0 || if0.err !== 1'b0) begin bad++; $display("FAIL mid_flags: got done=%b err=%b expected 0 0", if0.done, if0.err); end
        @(negedge clk);
        stuck0 = 8'h00;
        rst = 1'b0;
        @(negedge clk);
        total++; if (if0.tgt_ready !== 1'b1 || if0.busy !== 1'b0) begin bad++; $display("FAIL mid_release: got ready=%b busy=%b expected 1 0", if0.tgt_ready, if0.busy); end
        total++; if (if0.done !== 1'b0 || if0.err !== 1'b0) begin bad++; $display("FAIL mid_nopulse: got done=%b err=%b expected 0 0", if0.done, if0.err); end
        $display("txn reset mid-operation");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dc_modes();
        test_retry_err();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
